// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory-wait timeout and sticky fault.
// Define CTRL_UTYPE_EN to add LUI/AUIPC support (ALUOp=11).
module multicycle_controller #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic       jmp_sel,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StFault  = 3'd5
  } state_e;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
`ifdef CTRL_UTYPE_EN
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
`endif

  // A zero-width counter is illegal, so WAIT_MAX=0 keeps a single unused bit.
  localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_e          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            timeout;

  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    ok = (op == OpR) || (op == OpI) || (op == OpLw) || (op == OpSw) || (op == OpBr) ||
         (op == OpJal) || (op == OpJalr);
`ifdef CTRL_UTYPE_EN
    ok = ok || (op == OpLui) || (op == OpAuipc);
`endif
    return ok;
  endfunction

  assign timeout = (WAIT_MAX > 0) && (wait_q == WaitLast) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mem_req  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 2'b00;
    Branch   = 1'b0;
    jmp_sel  = 1'b0;
    fault    = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        // Gated by reset so an asserted reset never presents a load strobe.
        IRWrite = mem_ready && rst_n;
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StFault;
      end
      StDecode: begin
        op_d    = Opcode;
        state_d = op_supported(Opcode) ? StExec : StFault;
      end
      StExec: begin
        case (op_q)
          OpR: begin
            ALUOp   = 2'b10;
            state_d = StWb;
          end
          OpI: begin
            ALUSrc  = 1'b1;
            ALUOp   = 2'b10;
            state_d = StWb;
          end
          OpLw, OpSw: begin
            ALUSrc  = 1'b1;
            state_d = StMem;
          end
          OpBr: begin
            ALUOp   = 2'b01;
            Branch  = 1'b1;
            PCWrite = 1'b1;
            state_d = StFetch;
          end
          OpJal, OpJalr: state_d = StWb;
`ifdef CTRL_UTYPE_EN
          OpLui, OpAuipc: begin
            ALUSrc  = 1'b1;
            ALUOp   = 2'b11;
            state_d = StWb;
          end
`endif
          default: state_d = StFault;
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        if (op_q == OpLw) begin
          MemRead = 1'b1;
          if (mem_ready) state_d = StWb;
        end else begin
          MemWrite = 1'b1;
          if (mem_ready) begin
            PCWrite = 1'b1;
            state_d = StFetch;
          end
        end
        if (!mem_ready && timeout) state_d = StFault;
      end
      StWb: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = (op_q == OpLw);
        jmp_sel  = (op_q == OpJal) || (op_q == OpJalr);
        Branch   = (op_q == OpJal);
        state_d  = StFetch;
      end
      StFault: fault = 1'b1;
      default: state_d = StFault;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q || mem_ready) begin
      wait_d = '0;
    end else if (state_q == StFetch || state_q == StMem) begin
      wait_d = wait_q + CntW'(1);
    end
  end

  assign state = state_q;

endmodule
